nt_update_scheduler: RTL

NT_UPDATE_SCHEDULER -- requirements
Module: nt_update_scheduler

---
 rtl/nt_pkg.sv | 36 +++
 rtl/nt_update_scheduler_if.sv | 35 +++
 rtl/nt_prescaler.sv | 35 +++
 rtl/nt_update_scheduler.sv | 127 ++++++++++++
 4 files changed

// File: rtl/nt_pkg.sv
// -----------------------------------------------------------------------------
// nt_pkg
// Shared constants and types for the neurotransmitter level update scheduler:
// channel count and level width, reset level, channel-index constants, the
// scheduler FSM state encoding and a helper for advancing the channel index.
// -----------------------------------------------------------------------------
package nt_pkg;

   localparam int NUM_CH   = 5;
   localparam int LEVEL_W  = 2;
   localparam int LEVELS_W = NUM_CH * LEVEL_W;
   localparam int IDX_W    = 3;
   localparam int PERIOD_W = 8;

   // Every channel starts at level 1.
   localparam logic [LEVELS_W-1:0] RESET_LEVEL = 10'h155;

   localparam int CH_CORTISOL       = 0;
   localparam int CH_DOPAMINE       = 1;
   localparam int CH_GABA           = 2;
   localparam int CH_NOREPINEPHRINE = 3;
   localparam int CH_SEROTONIN      = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   // Round-robin successor of a channel index, wrapping after the last channel.
   function automatic logic [IDX_W-1:0] next_channel(input logic [IDX_W-1:0] idx,
                                                     input int num_ch);
      return (idx == IDX_W'(num_ch - 1)) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/nt_update_scheduler_if.sv
// -----------------------------------------------------------------------------
// nt_update_scheduler_if
// Bundle of the scheduler's control and level signals.
//   master : drives enable, period, level_next, freeze_mask, load, load_value;
//            observes level_q, update_strobe, channel_idx, round_done, busy.
//   slave  : the scheduler side (directions reversed).
// -----------------------------------------------------------------------------
interface nt_update_scheduler_if #(
   parameter int NUM_CH  = nt_pkg::NUM_CH,
   parameter int LEVEL_W = nt_pkg::LEVEL_W
);

   logic                          enable;
   logic [nt_pkg::PERIOD_W-1:0]   period;
   logic [NUM_CH*LEVEL_W-1:0]     level_next;
   logic [NUM_CH-1:0]             freeze_mask;
   logic                          load;
   logic [NUM_CH*LEVEL_W-1:0]     load_value;
   logic [NUM_CH*LEVEL_W-1:0]     level_q;
   logic [NUM_CH-1:0]             update_strobe;
   logic [nt_pkg::IDX_W-1:0]      channel_idx;
   logic                          round_done;
   logic                          busy;

   modport master (
      output enable, period, level_next, freeze_mask, load, load_value,
      input  level_q, update_strobe, channel_idx, round_done, busy
   );

   modport slave (
      input  enable, period, level_next, freeze_mask, load, load_value,
      output level_q, update_strobe, channel_idx, round_done, busy
   );

endinterface

// File: rtl/nt_prescaler.sv
// -----------------------------------------------------------------------------
// nt_prescaler
// Down-counter that paces commit slots. A load captures reload_value; otherwise
// the count decrements until it reaches zero. expired is high while the count
// reads 1, i.e. in the last wait cycle before a commit.
//   clk, rst      : clock, synchronous active-high reset (count -> 0)
//   reload_value  : value captured on load
//   load          : capture reload_value at the next edge
//   expired       : count == 1
// -----------------------------------------------------------------------------
module nt_prescaler #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] reload_value,
   input  logic         load,
   output logic         expired
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= reload_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign expired = (count == W'(1));

endmodule

// File: rtl/nt_update_scheduler.sv
// -----------------------------------------------------------------------------
// nt_update_scheduler
// Commits proposed neurotransmitter levels one channel at a time, round-robin,
// with a programmable number of wait cycles between commit slots. Frozen
// channels are skipped for writing but still consume their slot. A force-load
// overwrites all levels and wins over a coincident commit write.
//   clk, rst : clock, synchronous active-high reset
//   bus      : nt_update_scheduler_if.slave
//              in  enable, period, level_next, freeze_mask, load, load_value
//              out level_q, update_strobe, channel_idx, round_done, busy
// Level field of channel i is bits [2i+1:2i]:
//   0 cortisol, 1 dopamine, 2 gaba, 3 norepinephrine, 4 serotonin.
// -----------------------------------------------------------------------------
module nt_update_scheduler #(
   parameter int                          NUM_CH      = nt_pkg::NUM_CH,
   parameter int                          LEVEL_W     = nt_pkg::LEVEL_W,
   parameter logic [NUM_CH*LEVEL_W-1:0]   RESET_LEVEL = nt_pkg::RESET_LEVEL
) (
   input  logic                 clk,
   input  logic                 rst,
   nt_update_scheduler_if.slave bus
);

   import nt_pkg::*;

   localparam int LVL_W = NUM_CH * LEVEL_W;

   state_t               state;
   state_t               state_nxt;
   logic [IDX_W-1:0]     idx;
   logic [LVL_W-1:0]     level;
   logic [LVL_W-1:0]     level_commit;
   logic [NUM_CH-1:0]    strobe;
   logic                 commit;
   logic                 pre_load;
   logic                 pre_expired;

   nt_prescaler #(.W(PERIOD_W)) u_prescaler (
      .clk          (clk),
      .rst          (rst),
      .reload_value (bus.period),
      .load         (pre_load),
      .expired      (pre_expired)
   );

   // FSM state register, channel pointer and committed levels
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         idx   <= '0;
         level <= RESET_LEVEL;
      end else begin
         state <= state_nxt;
         if (commit) begin
            // Advances even for a frozen channel.
            idx <= next_channel(idx, NUM_CH);
         end
         level <= bus.load ? bus.load_value : level_commit;
      end
   end

   // Next-state logic; the prescaler is reloaded on every entry into WAIT, so
   // period is only sampled at slot boundaries.
   always_comb begin
      state_nxt = state;
      pre_load  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.enable) begin
               if (bus.period == '0) begin
                  state_nxt = ST_COMMIT;
               end else begin
                  state_nxt = ST_WAIT;
                  pre_load  = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (!bus.enable) begin
               state_nxt = ST_IDLE;
            end else if (pre_expired) begin
               state_nxt = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            if (!bus.enable) begin
               state_nxt = ST_IDLE;
            end else if (bus.period == '0) begin
               state_nxt = ST_COMMIT;
            end else begin
               state_nxt = ST_WAIT;
               pre_load  = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign commit = (state == ST_COMMIT);

   // One-hot strobe of the slot channel, only during COMMIT
   always_comb begin
      strobe = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         strobe[i] = commit && (idx == IDX_W'(i));
      end
   end

   // Replace only the strobed, non-frozen field
   always_comb begin
      level_commit = level;
      for (int i = 0; i < NUM_CH; i++) begin
         if (strobe[i] && !bus.freeze_mask[i]) begin
            level_commit[i*LEVEL_W +: LEVEL_W] = bus.level_next[i*LEVEL_W +: LEVEL_W];
         end
      end
   end

   assign bus.level_q       = level;
   assign bus.update_strobe = strobe;
   assign bus.channel_idx   = idx;
   assign bus.round_done    = commit && (idx == IDX_W'(NUM_CH - 1));
   assign bus.busy          = (state != ST_IDLE);

endmodule
